axis_word_packer: RTL and testbench

- Packs a narrow AXI-Stream of fixed-width beats into one wide word per C_RATIO beats.
- Sits directly upstream of the 240-bit splitter that fans words out to the three datapath lanes.
- Beats are placed LSB-first.
- A one-word holding stage lets the input keep streaming while the downstream consumer stalls.

---
 rtl/axis_word_packer_pkg.sv | 18 +
 rtl/axis_word_packer_out_stage.sv | 69 ++++++
 rtl/axis_word_packer.sv | 130 +++++++++++++
 tb/tb_axis_word_packer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_word_packer_pkg.sv
// Shared defaults and helpers for the axis_word_packer slice.
package axis_word_packer_pkg;

  localparam int unsigned DEF_S_WIDTH = 24;
  localparam int unsigned DEF_RATIO   = 10;
  localparam int unsigned DEF_M_WIDTH = DEF_S_WIDTH * DEF_RATIO;
  localparam int unsigned DEF_CNT_W   = $clog2(DEF_RATIO);

  function automatic int unsigned cnt_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Bit offset of beat k inside the packed word; beats are placed LSB-first.
  function automatic int unsigned slice_offset(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/axis_word_packer_out_stage.sv
// Output holding register of axis_word_packer; owns m_axis_* and out_free.
// Carries m_axis_tlast only when AXIS_WORD_PACKER_TLAST_EN is defined.
module axis_word_packer_out_stage
  import axis_word_packer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_M_WIDTH
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
`ifdef AXIS_WORD_PACKER_TLAST_EN
  input  logic              load_last,
  output logic              m_axis_tlast,
`endif
  input  logic              m_axis_tready,
  output logic              out_free,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
`ifdef AXIS_WORD_PACKER_TLAST_EN
  logic              out_last_q, out_last_d;
`endif

  assign out_free      = !out_valid_q | m_axis_tready;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
`ifdef AXIS_WORD_PACKER_TLAST_EN
  assign m_axis_tlast  = out_last_q;
`endif

  // The caller only asserts load when out_free, so data never changes under a stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef AXIS_WORD_PACKER_TLAST_EN
    out_last_d  = out_last_q;
`endif
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
`ifdef AXIS_WORD_PACKER_TLAST_EN
      out_last_d  = load_last;
`endif
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef AXIS_WORD_PACKER_TLAST_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef AXIS_WORD_PACKER_TLAST_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

endmodule

// File: rtl/axis_word_packer.sv
// Packs C_RATIO narrow AXI-Stream beats LSB-first into one wide word.
// Define AXIS_WORD_PACKER_TLAST_EN to add tlast ports and early word close.
module axis_word_packer
  import axis_word_packer_pkg::*;
#(
  parameter  int unsigned C_S_AXIS_TDATA_WIDTH = DEF_S_WIDTH,
  parameter  int unsigned C_RATIO              = DEF_RATIO,
  localparam int unsigned C_M_AXIS_TDATA_WIDTH = C_S_AXIS_TDATA_WIDTH * C_RATIO
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
`ifdef AXIS_WORD_PACKER_TLAST_EN
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tlast,
`endif
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata
);

  localparam int unsigned W     = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned MW    = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned CNT_W = cnt_width(C_RATIO);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(C_RATIO - 1);

  logic [MW-1:0]    acc_q, acc_d, merged, load_data;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_full_q, acc_full_d;
  logic             beat_fire, beat_last, closing, out_free, load;
`ifdef AXIS_WORD_PACKER_TLAST_EN
  logic             acc_last_q, acc_last_d, load_last;
  assign beat_last = s_axis_tlast;
`else
  assign beat_last = 1'b0;
`endif

  // Ready depends only on reset and the held-word flag, never on m_axis_tready.
  assign s_axis_tready = aresetn & !acc_full_q;
  assign beat_fire     = s_axis_tvalid & s_axis_tready;
  assign closing       = beat_fire & ((cnt_q == LAST_SLICE) | beat_last);

  always_comb begin
    merged = acc_q;
    for (int k = 0; k < C_RATIO; k++) begin
      if (cnt_q == CNT_W'(k)) merged[slice_offset(k, W) +: W] = s_axis_tdata;
    end
  end

  // A held word always drains before new beats, since ready is low while it waits.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    acc_full_d = acc_full_q;
    load       = 1'b0;
    load_data  = merged;
`ifdef AXIS_WORD_PACKER_TLAST_EN
    acc_last_d = acc_last_q;
    load_last  = beat_last;
`endif
    if (acc_full_q) begin
      load_data = acc_q;
`ifdef AXIS_WORD_PACKER_TLAST_EN
      load_last = acc_last_q;
`endif
      if (out_free) begin
        load       = 1'b1;
        acc_d      = '0;
        acc_full_d = 1'b0;
        cnt_d      = '0;
`ifdef AXIS_WORD_PACKER_TLAST_EN
        acc_last_d = 1'b0;
`endif
      end
    end else if (closing) begin
      if (out_free) begin
        load  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d      = merged;
        acc_full_d = 1'b1;
`ifdef AXIS_WORD_PACKER_TLAST_EN
        acc_last_d = beat_last;
`endif
      end
    end else if (beat_fire) begin
      acc_d = merged;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      acc_full_q <= 1'b0;
`ifdef AXIS_WORD_PACKER_TLAST_EN
      acc_last_q <= 1'b0;
`endif
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      acc_full_q <= acc_full_d;
`ifdef AXIS_WORD_PACKER_TLAST_EN
      acc_last_q <= acc_last_d;
`endif
    end
  end

  axis_word_packer_out_stage #(
    .DATA_W(MW)
  ) u_out_stage (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .load         (load),
    .load_data    (load_data),
`ifdef AXIS_WORD_PACKER_TLAST_EN
    .load_last    (load_last),
    .m_axis_tlast (m_axis_tlast),
`endif
    .m_axis_tready(m_axis_tready),
    .out_free     (out_free),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_word_packer.sv
// Scoreboard bench for axis_word_packer: a word-level model feeds an expected
// queue, and an independent monitor checks every output handshake against it.
module tb_axis_word_packer;

  localparam int W  = 24;
  localparam int R  = 10;
  localparam int MW = W * R;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_tvalid;
  logic          s_tready;
  logic [W-1:0]  s_tdata;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [MW-1:0] m_tdata;
  logic          m_tlast;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int wait_cycles = 0;
  int word_count  = 0;
  bit rdy_rand    = 0;

  logic [W-1:0]  part[$];
  logic [MW-1:0] exp_q[$];
  bit            exp_last_q[$];
  int            hs_cycles[$];

  bit            held_valid = 0;
  logic [MW-1:0] held_data;

  axis_word_packer dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
`ifdef AXIS_WORD_PACKER_TLAST_EN
    .s_axis_tlast (s_tlast),
    .m_axis_tlast (m_tlast),
`endif
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata)
  );

`ifndef AXIS_WORD_PACKER_TLAST_EN
  assign m_tlast = 1'b0;
`endif

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    if (rdy_rand) m_tready = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] packBeats(input logic [W-1:0] beats[$]);
    logic [MW-1:0] word = '0;
    foreach (beats[k]) word = word | (MW'(beats[k]) << (k * W));
    return word;
  endfunction

  // Reference model: collect accepted beats, emit a word on R beats or tlast.
  task automatic modelAccept(input logic [W-1:0] data, input logic last);
    bit closes;
    part.push_back(data);
    closes = (part.size() == R);
`ifdef AXIS_WORD_PACKER_TLAST_EN
    closes = closes | last;
`endif
    if (closes) begin
      exp_q.push_back(packBeats(part));
      exp_last_q.push_back(closes && (last || 1'b0)
`ifndef AXIS_WORD_PACKER_TLAST_EN
        && 1'b0
`endif
      );
      part.delete();
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input logic last);
    int guard = 0;
    bit done  = 0;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    while (!done) begin
      @(negedge aclk);
      if (s_tready) begin
        modelAccept(data, last);
        done = 1;
      end else begin
        wait_cycles++;
        guard++;
        if (guard > 500) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL accept_timeout: got no s_axis_tready, expected acceptance of 0x%0h", data);
          done = 1;
        end
      end
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    rdy_rand = 0;
    #0;
    m_tready = 1'b1;
    while ((exp_q.size() != 0 || m_tvalid) && guard < 300) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
    checkOutput("drain_valid", m_tvalid, 0);
  endtask

  // Monitor: every handshake pops one expected word; stalls must hold data.
  always @(negedge aclk) begin
    if (!aresetn) begin
      held_valid = 0;
    end else begin
      if (held_valid) begin
        checkOutput("valid_held", m_tvalid, 1'b1);
        if (m_tvalid) checkOutput("data_stable", m_tdata, held_data);
      end
      if (m_tvalid && m_tready) begin
        hs_cycles.push_back(cyc);
        word_count++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", m_tdata);
        end else begin
          checkOutput("word_data", m_tdata, exp_q.pop_front());
          checkOutput("word_last", m_tlast, exp_last_q.pop_front());
        end
        held_valid = 0;
      end else if (m_tvalid) begin
        held_valid = 1;
        held_data  = m_tdata;
      end else begin
        held_valid = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected end of run");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [W-1:0] d;
    logic l;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_m_tvalid", m_tvalid, 1'b0);
    checkOutput("rst_s_tready", s_tready, 1'b0);
    checkOutput("rst_m_tdata", m_tdata, '0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checkOutput("post_rst_s_tready", s_tready, 1'b1);

    // Single word 0x00000A..000001 with one-cycle latency.
    for (int i = 1; i <= R; i++) begin
      applyStimulus(W'(i), 1'b0);
      if (i == R - 1) checkOutput("pre_close_valid", m_tvalid, 1'b0);
    end
    idle();
    checkOutput("latency_valid", m_tvalid, 1'b1);
    drain();

    // Back-to-back words with no bubbles.
    wait_cycles = 0;
    hs_cycles.delete();
    for (int i = 0; i < 3 * R; i++) applyStimulus(W'($urandom), 1'b0);
    idle();
    drain();
    checkOutput("stream_no_stall", wait_cycles, 0);
    checkOutput("stream_words", hs_cycles.size(), 3);
    if (hs_cycles.size() == 3) begin
      checkOutput("stream_spacing_1", hs_cycles[1] - hs_cycles[0], R);
      checkOutput("stream_spacing_2", hs_cycles[2] - hs_cycles[1], R);
    end

    // Downstream stall: word 1 held in output, word 2 held in accumulator.
    m_tready = 1'b0;
    wait_cycles = 0;
    hs_cycles.delete();
    for (int i = 0; i < 2 * R; i++) applyStimulus(W'($urandom), 1'b0);
    idle();
    checkOutput("stall_no_early_block", wait_cycles, 0);
    checkOutput("stall_tready_low", s_tready, 1'b0);
    repeat (5) begin
      @(posedge aclk);
      #1;
      checkOutput("stall_tready_held", s_tready, 1'b0);
    end
    checkOutput("stall_expected_words", exp_q.size(), 2);
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    checkOutput("release_tready", s_tready, 1'b1);
    checkOutput("release_held_valid", m_tvalid, 1'b1);
    drain();
    checkOutput("release_words", hs_cycles.size(), 2);
    if (hs_cycles.size() == 2) checkOutput("release_spacing", hs_cycles[1] - hs_cycles[0], 1);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 4; i++) applyStimulus(W'($urandom), 1'b0);
    idle();
    aresetn = 1'b0;
    part.delete();
    exp_q.delete();
    exp_last_q.delete();
    repeat (3) begin
      @(posedge aclk);
      #1;
      checkOutput("midrst_m_tvalid", m_tvalid, 1'b0);
      checkOutput("midrst_m_tlast", m_tlast, 1'b0);
      checkOutput("midrst_s_tready", s_tready, 1'b0);
    end
    aresetn = 1'b1;
    base = word_count;
    for (int i = 0; i < R; i++) applyStimulus(W'(32'h100 + i), 1'b0);
    idle();
    drain();
    checkOutput("reset_word_count", word_count - base, 1);

`ifdef AXIS_WORD_PACKER_TLAST_EN
    // Short packet closed by tlast; the following word restarts at slice 0.
    applyStimulus(24'hAAAAAA, 1'b0);
    applyStimulus(24'hBBBBBB, 1'b0);
    applyStimulus(24'hCCCCCC, 1'b1);
    idle();
    checkOutput("tlast_valid", m_tvalid, 1'b1);
    checkOutput("tlast_word", m_tdata, {168'b0, 72'hCCCCCC_BBBBBB_AAAAAA});
    checkOutput("tlast_flag", m_tlast, 1'b1);
    for (int i = 0; i < R; i++) applyStimulus(W'(i + 1), (i == R - 1));
    idle();
    drain();
`endif

    // Random traffic with random gaps and random downstream back-pressure.
    rdy_rand = 1;
    for (int i = 0; i < 12 * R; i++) begin
      d = W'($urandom);
      l = 1'b0;
`ifdef AXIS_WORD_PACKER_TLAST_EN
      l = ($urandom_range(0, 7) == 0) || (i == 12 * R - 1);
`endif
      applyStimulus(d, l);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
    end
    idle();
    drain();
    checkOutput("random_partial_left", part.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
